// File: rtl/spu_pkg.sv
// Shared types, sizes and hazard helpers for the SPU dual-issue scoreboard.
// Latency: combinational helpers only, no state.
// Backpressure: none; callers gate issue on the hazard_free result.
package spu_pkg;

   localparam int NREGS    = 128;  // GPRs tracked
   localparam int REGBITS  = 7;    // register index width
   localparam int LAT_BITS = 3;    // latency field width, max latency 7

   // One decode slot as presented to the scoreboard.
   typedef struct packed {
      logic                valid;
      logic [REGBITS-1:0]  ra;
      logic [REGBITS-1:0]  rb;
      logic [REGBITS-1:0]  rt;
      logic                use_ra;
      logic                use_rb;
      logic                wr_rt;
      logic [LAT_BITS-1:0] lat;
   } slot_t;

   // A write to r0 or with zero latency never occupies a scoreboard entry.
   function automatic logic eff_write(input slot_t s);
      return s.wr_rt && (s.rt != '0) && (s.lat != '0);
   endfunction

   // Sources ready and destination free. busy[0] is always 0, so r0 is
   // implicitly ready.
   function automatic logic hazard_free(input slot_t s, input logic [NREGS-1:0] busy);
      return (!s.use_ra || !busy[s.ra]) &&
             (!s.use_rb || !busy[s.rb]) &&
             (!eff_write(s) || !busy[s.rt]);
   endfunction

endpackage

// File: rtl/spu_sb_entry.sv
// Single register latency countdown: loads on set, counts down to 0, cleared by flush.
// Latency: cnt updates on the rising edge after set/flush.
// Backpressure: none; the issuing logic guarantees set only when cnt == 0.
// Ports: clk, rst_n (async active-low), flush, set, set_lat, cnt (current countdown).
module spu_sb_entry
   import spu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                set,
   input  logic [LAT_BITS-1:0] set_lat,
   output logic [LAT_BITS-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (flush)
         cnt <= '0;
      else if (set)
         cnt <= set_lat;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

endmodule

// File: rtl/spu_issue_scoreboard.sv
// Dual-issue scoreboard: grants even (slot 0) and odd (slot 1, younger) pipes
// under RAW/WAW/intra-pair/program-order rules. Grants are combinational,
// busy_vec reflects state updated on the rising edge. A slot is held upstream
// until granted; flush or reset suppresses all grants.
// Ports: clk, rst_n, slot 0/1 fields (valid, ra, rb, rt, use_ra, use_rb,
// wr_rt, lat), flush, issue_0/1, busy_vec, stall_cnt_0/1.
// Optional: define SPU_STALL_CNT_EN to build the per-slot stall counters;
// otherwise stall_cnt_0/1 are tied to 0.
module spu_issue_scoreboard
   import spu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_0,
   input  logic [REGBITS-1:0]  ra_0,
   input  logic [REGBITS-1:0]  rb_0,
   input  logic [REGBITS-1:0]  rt_0,
   input  logic                use_ra_0,
   input  logic                use_rb_0,
   input  logic                wr_rt_0,
   input  logic [LAT_BITS-1:0] lat_0,
   input  logic                valid_1,
   input  logic [REGBITS-1:0]  ra_1,
   input  logic [REGBITS-1:0]  rb_1,
   input  logic [REGBITS-1:0]  rt_1,
   input  logic                use_ra_1,
   input  logic                use_rb_1,
   input  logic                wr_rt_1,
   input  logic [LAT_BITS-1:0] lat_1,
   input  logic                flush,
   output logic                issue_0,
   output logic                issue_1,
   output logic [NREGS-1:0]    busy_vec,
   output logic [31:0]         stall_cnt_0,
   output logic [31:0]         stall_cnt_1
);

   slot_t s0, s1;
   logic  eff0, eff1;
   logic  pair_hazard;

   assign s0 = '{valid: valid_0, ra: ra_0, rb: rb_0, rt: rt_0, use_ra: use_ra_0,
                 use_rb: use_rb_0, wr_rt: wr_rt_0, lat: lat_0};
   assign s1 = '{valid: valid_1, ra: ra_1, rb: rb_1, rt: rt_1, use_ra: use_ra_1,
                 use_rb: use_rb_1, wr_rt: wr_rt_1, lat: lat_1};

   assign eff0 = eff_write(s0);
   assign eff1 = eff_write(s1);

   // Slot 1 cannot consume or overwrite the result of the slot 0 instruction
   // issuing alongside it, since there is no forwarding inside the pair.
   assign pair_hazard = issue_0 && eff0 &&
                        ((s1.use_ra && (s1.ra == s0.rt)) ||
                         (s1.use_rb && (s1.rb == s0.rt)) ||
                         (eff1 && (s1.rt == s0.rt)));

   // rst_n gates the grants so they drop asynchronously with reset.
   assign issue_0 = rst_n && s0.valid && !flush && hazard_free(s0, busy_vec);

   // Program order: the younger slot never overtakes a held older slot.
   assign issue_1 = rst_n && s1.valid && !flush && (issue_0 || !s0.valid) &&
                    hazard_free(s1, busy_vec) && !pair_hazard;

   assign busy_vec[0] = 1'b0;

   for (genvar r = 1; r < NREGS; r++) begin : g_entry
      logic                set0, set1;
      logic [LAT_BITS-1:0] cnt;

      // set0 and set1 are mutually exclusive for a given r (intra-pair WAW).
      assign set0 = issue_0 && eff0 && (s0.rt == REGBITS'(r));
      assign set1 = issue_1 && eff1 && (s1.rt == REGBITS'(r));

      spu_sb_entry u_entry (
         .clk     (clk),
         .rst_n   (rst_n),
         .flush   (flush),
         .set     (set0 || set1),
         .set_lat (set0 ? s0.lat : s1.lat),
         .cnt     (cnt)
      );

      assign busy_vec[r] = (cnt != '0);
   end

`ifdef SPU_STALL_CNT_EN
   logic [31:0] stall_q_0, stall_q_1;

   // Flush cycles are not stalls; counters wrap naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q_0 <= '0;
         stall_q_1 <= '0;
      end else begin
         if (valid_0 && !issue_0 && !flush)
            stall_q_0 <= stall_q_0 + 32'd1;
         if (valid_1 && !issue_1 && !flush)
            stall_q_1 <= stall_q_1 + 32'd1;
      end
   end

   assign stall_cnt_0 = stall_q_0;
   assign stall_cnt_1 = stall_q_1;
`else
   assign stall_cnt_0 = '0;
   assign stall_cnt_1 = '0;
`endif

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed bench for spu_issue_scoreboard: reset, latency, RAW/WAW, intra-pair,
// order, flush and async reset scenarios with hand-computed expectations.
module tb_spu_issue_scoreboard;
   import spu_pkg::*;

   logic                clk;
   logic                rst_n;
   logic                valid_0, valid_1;
   logic [REGBITS-1:0]  ra_0, rb_0, rt_0, ra_1, rb_1, rt_1;
   logic                use_ra_0, use_rb_0, wr_rt_0, use_ra_1, use_rb_1, wr_rt_1;
   logic [LAT_BITS-1:0] lat_0, lat_1;
   logic                flush;
   logic                issue_0, issue_1;
   logic [NREGS-1:0]    busy_vec;
   logic [31:0]         stall_cnt_0, stall_cnt_1;

   int checks   = 0;
   int failures = 0;

   spu_issue_scoreboard dut (
      .clk(clk), .rst_n(rst_n),
      .valid_0(valid_0), .ra_0(ra_0), .rb_0(rb_0), .rt_0(rt_0),
      .use_ra_0(use_ra_0), .use_rb_0(use_rb_0), .wr_rt_0(wr_rt_0), .lat_0(lat_0),
      .valid_1(valid_1), .ra_1(ra_1), .rb_1(rb_1), .rt_1(rt_1),
      .use_ra_1(use_ra_1), .use_rb_1(use_rb_1), .wr_rt_1(wr_rt_1), .lat_1(lat_1),
      .flush(flush), .issue_0(issue_0), .issue_1(issue_1), .busy_vec(busy_vec),
      .stall_cnt_0(stall_cnt_0), .stall_cnt_1(stall_cnt_1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [REGBITS-1:0] ra, input logic [REGBITS-1:0] rb,
                         input logic [REGBITS-1:0] rt, input logic ua, input logic ub,
                         input logic wr, input logic [LAT_BITS-1:0] lat);
      valid_0 = v; ra_0 = ra; rb_0 = rb; rt_0 = rt;
      use_ra_0 = ua; use_rb_0 = ub; wr_rt_0 = wr; lat_0 = lat;
   endtask

   task automatic drive1(input logic v, input logic [REGBITS-1:0] ra, input logic [REGBITS-1:0] rb,
                         input logic [REGBITS-1:0] rt, input logic ua, input logic ub,
                         input logic wr, input logic [LAT_BITS-1:0] lat);
      valid_1 = v; ra_1 = ra; rb_1 = rb; rt_1 = rt;
      use_ra_1 = ua; use_rb_1 = ub; wr_rt_1 = wr; lat_1 = lat;
   endtask

   task automatic idle();
      drive0(1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 3'd0);
      drive1(1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 3'd0);
      flush = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [NREGS-1:0] exp;
      idle();
      rst_n = 1'b0;
      // Valid, hazard-free slots held during reset must still see no grant.
      drive0(1'b1, 7'd5, 7'd6, 7'd10, 1'b1, 1'b1, 1'b1, 3'd4);
      drive1(1'b1, 7'd1, 7'd2, 7'd11, 1'b1, 1'b1, 1'b1, 3'd2);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (issue_0 !== 1'b0 || issue_1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_grants cyc%0d: got %b%b expected 00", c, issue_0, issue_1);
         end
         tick();
      end
      exp = '0;
      checks++;
      if (busy_vec !== exp || stall_cnt_0 !== 32'd0 || stall_cnt_1 !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: busy=%h sc0=%0d sc1=%0d expected 0", busy_vec, stall_cnt_0, stall_cnt_1);
      end
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [NREGS-1:0] exp;
      apply_reset();
      drive0(1'b1, 7'd5, 7'd6, 7'd10, 1'b1, 1'b1, 1'b1, 3'd4);
      @(negedge clk);
      checks++;
      if (issue_0 !== 1'b1 || issue_1 !== 1'b0 || busy_vec !== '0) begin
         failures++;
         $display("FAIL basic_issue: issue0=%b issue1=%b busy=%h expected 1 0 0", issue_0, issue_1, busy_vec);
      end
      tick();
      idle();
      for (int k = 1; k <= 6; k++) begin
         exp = '0;
         if (k <= 4) exp[10] = 1'b1;
         @(negedge clk);
         checks++;
         if (busy_vec !== exp) begin
            failures++;
            $display("FAIL basic_busy cyc%0d: got %h expected %h", k, busy_vec, exp);
         end
         tick();
      end
   endtask

   task automatic test_raw_stall();
      logic [31:0] exp_sc;
      apply_reset();
      drive0(1'b1, 7'd0, 7'd0, 7'd10, 1'b0, 1'b0, 1'b1, 3'd4);
      @(negedge clk);
      checks++;
      if (issue_0 !== 1'b1) begin
         failures++;
         $display("FAIL raw_producer: got %b expected 1", issue_0);
      end
      tick();
      drive0(1'b1, 7'd10, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 3'd0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks++;
         if (issue_0 !== (k == 5)) begin
            failures++;
            $display("FAIL raw_consumer cyc%0d: got %b expected %b", k, issue_0, (k == 5));
         end
         tick();
      end
      idle();
`ifdef SPU_STALL_CNT_EN
      exp_sc = 32'd4;
`else
      exp_sc = 32'd0;
`endif
      checks++;
      if (stall_cnt_0 !== exp_sc || stall_cnt_1 !== 32'd0) begin
         failures++;
         $display("FAIL raw_stall_cnt: sc0=%0d sc1=%0d expected %0d 0", stall_cnt_0, stall_cnt_1, exp_sc);
      end
   endtask

   task automatic test_intra_pair();
      apply_reset();
      drive0(1'b1, 7'd0, 7'd0, 7'd20, 1'b0, 1'b0, 1'b1, 3'd2);
      drive1(1'b1, 7'd20, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 3'd0);
      @(negedge clk);
      checks++;
      if (issue_0 !== 1'b1 || issue_1 !== 1'b0) begin
         failures++;
         $display("FAIL pair_raw: got %b%b expected 10", issue_0, issue_1);
      end
      tick();
      drive0(1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0, 3'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (issue_1 !== (k == 3) || issue_0 !== 1'b0) begin
            failures++;
            $display("FAIL pair_held cyc%0d: issue1=%b expected %b", k, issue_1, (k == 3));
         end
         tick();
      end
      idle();
      // Intra-pair WAW on a free register.
      apply_reset();
      drive0(1'b1, 7'd0, 7'd0, 7'd21, 1'b0, 1'b0, 1'b1, 3'd1);
      drive1(1'b1, 7'd0, 7'd0, 7'd21, 1'b0, 1'b0, 1'b1, 3'd1);
      @(negedge clk);
      checks++;
      if (issue_0 !== 1'b1 || issue_1 !== 1'b0) begin
         failures++;
         $display("FAIL pair_waw: got %b%b expected 10", issue_0, issue_1);
      end
      tick();
      idle();
   endtask

   task automatic test_waw_r0();
      apply_reset();
      drive0(1'b1, 7'd0, 7'd0, 7'd7, 1'b0, 1'b0, 1'b1, 3'd6);
      tick();
      drive0(1'b1, 7'd0, 7'd0, 7'd7, 1'b0, 1'b0, 1'b1, 3'd1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         checks++;
         if (issue_0 !== (k == 7)) begin
            failures++;
            $display("FAIL waw cyc%0d: got %b expected %b", k, issue_0, (k == 7));
         end
         tick();
      end
      idle();
      apply_reset();
      drive0(1'b1, 7'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 3'd6);
      @(negedge clk);
      checks++;
      if (issue_0 !== 1'b1) begin
         failures++;
         $display("FAIL r0_write_issue: got %b expected 1", issue_0);
      end
      tick();
      drive0(1'b1, 7'd0, 7'd0, 7'd0, 1'b1, 1'b1, 1'b0, 3'd0);
      @(negedge clk);
      checks++;
      if (busy_vec !== '0 || issue_0 !== 1'b1) begin
         failures++;
         $display("FAIL r0_read: busy=%h issue0=%b expected 0 1", busy_vec, issue_0);
      end
      tick();
      idle();
   endtask

   task automatic test_order();
      apply_reset();
      drive0(1'b1, 7'd0, 7'd0, 7'd3, 1'b0, 1'b0, 1'b1, 3'd2);
      tick();
      drive0(1'b1, 7'd3, 7'd0, 7'd0, 1'b1, 1'b0, 1'b0, 3'd0);
      drive1(1'b1, 7'd8, 7'd0, 7'd9, 1'b1, 1'b0, 1'b1, 3'd1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (issue_0 !== (k == 3) || issue_1 !== (k == 3)) begin
            failures++;
            $display("FAIL order cyc%0d: got %b%b expected %b%b", k, issue_0, issue_1, (k == 3), (k == 3));
         end
         tick();
      end
      idle();
   endtask

   task automatic test_flush_async_reset();
      logic [NREGS-1:0] exp;
      apply_reset();
      drive0(1'b1, 7'd0, 7'd0, 7'd4, 1'b0, 1'b0, 1'b1, 3'd5);
      tick();
      drive0(1'b1, 7'd1, 7'd0, 7'd11, 1'b1, 1'b0, 1'b1, 3'd3);
      drive1(1'b1, 7'd2, 7'd0, 7'd12, 1'b1, 1'b0, 1'b1, 3'd3);
      flush = 1'b1;
      exp = '0;
      exp[4] = 1'b1;
      @(negedge clk);
      checks++;
      if (issue_0 !== 1'b0 || issue_1 !== 1'b0 || busy_vec !== exp) begin
         failures++;
         $display("FAIL flush_cycle: grants=%b%b busy=%h expected 00 %h", issue_0, issue_1, busy_vec, exp);
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (busy_vec !== '0) begin
         failures++;
         $display("FAIL flush_clear: got %h expected 0", busy_vec);
      end
      tick();
      // Async reset with a pending entry and a grantable slot.
      drive0(1'b1, 7'd0, 7'd0, 7'd12, 1'b0, 1'b0, 1'b1, 3'd7);
      tick();
      drive0(1'b1, 7'd1, 7'd0, 7'd13, 1'b1, 1'b0, 1'b1, 3'd3);
      exp = '0;
      exp[12] = 1'b1;
      @(negedge clk);
      checks++;
      if (busy_vec !== exp || issue_0 !== 1'b1) begin
         failures++;
         $display("FAIL pre_arst: busy=%h issue0=%b expected %h 1", busy_vec, issue_0, exp);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy_vec !== '0 || issue_0 !== 1'b0 || issue_1 !== 1'b0) begin
         failures++;
         $display("FAIL arst_immediate: busy=%h grants=%b%b expected 0 00", busy_vec, issue_0, issue_1);
      end
      tick();
      idle();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #1;
      test_reset();
      test_basic();
      test_raw_stall();
      test_intra_pair();
      test_waw_r0();
      test_order();
      test_flush_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
